slave_in_port: RTL

//  Slave-side receiver for the serial system bus; the counterpart of master_out_port.

---
 rtl/slave_in_port.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/slave_in_port.sv
// Slave-side serial bus receiver. It deserialises the LSB-first address and
// burst streams, then either issues one read request or reassembles write
// words and presents one beat per word at base + beat index.
module slave_in_port #(
  parameter int WORD_SIZE       = 8,
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int BURST_SIZE      = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic                       m_valid,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic                       addr_bus,
  input  logic                       burst_size_bus,
  input  logic                       w_data_bus,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] addr_out,
  output logic [BURST_SIZE-1:0]      burst_out,
  output logic [WORD_SIZE-1:0]       wdata_out,
  output logic                       wdata_valid,
  output logic                       rd_req,
  output logic                       frame_done,
  output logic                       rx_err
);

  localparam int ACNT_W = $clog2(SLAVE_ADDR_SIZE + 1);
  localparam int WCNT_W = $clog2(WORD_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2
  } state_t;

  state_t state, state_d;

  logic                       op_rd;
  logic [ACNT_W-1:0]          acnt;
  logic [WCNT_W-1:0]          wcnt;
  logic [BURST_SIZE-1:0]      beat_idx;
  logic [SLAVE_ADDR_SIZE-1:0] addr_sr;
  logic [SLAVE_ADDR_SIZE-1:0] addr_nxt;
  logic [BURST_SIZE-1:0]      burst_sr;
  logic [BURST_SIZE-1:0]      burst_nxt;
  // Holds the first WORD_SIZE-1 bits; the final bit is taken straight from the bus.
  logic [WORD_SIZE-2:0]       wdata_sr;
  logic [WORD_SIZE-1:0]       word_nxt;

  logic bit_in, start_hit, op_legal, addr_last, word_last, beat_last;
  logic rd_req_d, wdata_valid_d, frame_done_d, rx_err_d, s_ready_d;

  // A zero burst count still moves one word, so the last beat index is 0.
  function automatic logic [BURST_SIZE-1:0] last_beat(input logic [BURST_SIZE-1:0] b);
    return (b == '0) ? '0 : b - BURST_SIZE'(1);
  endfunction

  assign bit_in    = sel & m_valid;
  // A new frame is only accepted once s_ready has been restored.
  assign start_hit = (state == IDLE) && s_ready && bit_in;
  assign op_legal  = read_en ^ write_en;
  assign addr_last = (state == ADDR) && bit_in && (acnt == ACNT_W'(SLAVE_ADDR_SIZE - 1));
  assign word_last = (state == WDATA) && bit_in && (wcnt == WCNT_W'(WORD_SIZE - 1));
  assign beat_last = word_last && (beat_idx == last_beat(burst_out));
  assign addr_nxt  = {addr_bus, addr_sr[SLAVE_ADDR_SIZE-1:1]};
  // Burst bits past the register width are dropped by freezing the shifter.
  assign burst_nxt = (acnt < ACNT_W'(BURST_SIZE)) ?
                     {burst_size_bus, burst_sr[BURST_SIZE-1:1]} : burst_sr;
  assign word_nxt  = {w_data_bus, wdata_sr};

  // State register and registered control pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_ready     <= 1'b1;
      rd_req      <= 1'b0;
      wdata_valid <= 1'b0;
      frame_done  <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      state       <= state_d;
      s_ready     <= s_ready_d;
      rd_req      <= rd_req_d;
      wdata_valid <= wdata_valid_d;
      frame_done  <= frame_done_d;
      rx_err      <= rx_err_d;
    end
  end

  // Next-state and next-pulse decode; sel loss mid-frame always aborts.
  always_comb begin
    state_d       = state;
    rd_req_d      = 1'b0;
    wdata_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    rx_err_d      = 1'b0;
    case (state)
      IDLE: begin
        if (start_hit) begin
          if (op_legal) state_d  = ADDR;
          else          rx_err_d = 1'b1;
        end
      end
      ADDR: begin
        if (!sel) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end else if (addr_last) begin
          if (op_rd) begin
            rd_req_d     = 1'b1;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (!sel) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end else if (word_last) begin
          wdata_valid_d = 1'b1;
          if (beat_last) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // s_ready comes back one cycle after the completing/erroring pulse.
    s_ready_d = (state_d == IDLE) && !frame_done_d && !rx_err_d;
  end

  // Shift registers, counters and parallel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rd     <= 1'b0;
      acnt      <= '0;
      wcnt      <= '0;
      beat_idx  <= '0;
      addr_sr   <= '0;
      burst_sr  <= '0;
      wdata_sr  <= '0;
      addr_out  <= '0;
      burst_out <= '0;
      wdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_hit && op_legal) begin
            op_rd    <= read_en;
            addr_sr  <= addr_nxt;
            burst_sr <= {burst_size_bus, burst_sr[BURST_SIZE-1:1]};
            acnt     <= ACNT_W'(1);
          end
        end
        ADDR: begin
          if (bit_in) begin
            addr_sr  <= addr_nxt;
            burst_sr <= burst_nxt;
            acnt     <= acnt + ACNT_W'(1);
            if (addr_last) begin
              addr_out  <= addr_nxt;
              burst_out <= burst_nxt;
              beat_idx  <= '0;
              wcnt      <= '0;
            end
          end
        end
        WDATA: begin
          if (bit_in) begin
            if (word_last) begin
              wdata_out <= word_nxt;
              addr_out  <= addr_sr + SLAVE_ADDR_SIZE'(beat_idx);
              beat_idx  <= beat_idx + BURST_SIZE'(1);
              wcnt      <= '0;
            end else begin
              wdata_sr <= word_nxt[WORD_SIZE-1:1];
              wcnt     <= wcnt + WCNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
